// File: rtl/game_clock_multi.sv
// N-player round-robin game clock with Fischer increment, pause and flag detection.
// Times are binary seconds; the display side does any decimal conversion.
module game_clock_multi #(
    parameter int p_players   = 2,
    parameter int p_time_w    = 8,
    parameter int p_divider   = 50_000_000,
    parameter int p_increment = 0
) (
    input  logic                            i_clk_50m,
    input  logic                            i_rst,
    input  logic                            i_restart,
    input  logic                            i_pause,
    input  logic [p_players-1:0]            i_move,
    input  logic [p_time_w-1:0]             i_init,
    output logic [p_players*p_time_w-1:0]   o_time,
    output logic [p_players-1:0]            o_active,
    output logic [1:0]                      o_state,
    output logic [p_players-1:0]            o_flag,
    output logic [p_players-1:0]            o_win,
    output logic                            o_sec
);

    localparam int pre_w     = $clog2(p_divider);
    localparam int time_max  = (2 ** p_time_w) - 1;
    localparam int inc_clamp = (p_increment > time_max) ? time_max : p_increment;
    localparam logic [p_time_w-1:0] inc_v    = p_time_w'(inc_clamp);
    localparam logic [pre_w-1:0]    pre_last = pre_w'(p_divider - 1);

    typedef enum logic [1:0] {
        st_idle  = 2'd0,
        st_run   = 2'd1,
        st_pause = 2'd2,
        st_flag  = 2'd3
    } state_t;

    state_t                 state_reg;
    logic [p_players-1:0]   active_reg;
    logic [p_players-1:0]   flag_reg;
    logic [p_players-1:0]   win_reg;
    logic [p_time_w-1:0]    time_reg [p_players];
    logic [pre_w-1:0]       pre_reg;
    logic                   sec_reg;

    logic [p_players-1:0]   move_low;
    logic [p_time_w-1:0]    active_time;

    function automatic logic [p_players-1:0] rot(input logic [p_players-1:0] x);
        return {x[p_players-2:0], x[p_players-1]};
    endfunction

    // The carry out of the widened add is exactly the overflow, since inc_v fits.
    function automatic logic [p_time_w-1:0] sat_inc(input logic [p_time_w-1:0] t);
        logic [p_time_w:0] s;
        s = {1'b0, t} + {1'b0, inc_v};
        return s[p_time_w] ? {p_time_w{1'b1}} : s[p_time_w-1:0];
    endfunction

    always_comb begin
        move_low    = i_move & (~i_move + p_players'(1));
        active_time = '0;
        for (int k = 0; k < p_players; k++) begin
            if (active_reg[k]) active_time = time_reg[k];
        end
    end

    always_ff @(posedge i_clk_50m) begin
        if (i_rst || i_restart) begin
            state_reg  <= st_idle;
            active_reg <= '0;
            flag_reg   <= '0;
            win_reg    <= '0;
            pre_reg    <= '0;
            sec_reg    <= 1'b0;
            for (int k = 0; k < p_players; k++) time_reg[k] <= i_init;
        end else begin
            sec_reg <= 1'b0;
            case (state_reg)
                st_idle: begin
                    if (|i_move) begin
                        state_reg  <= st_run;
                        active_reg <= rot(move_low);
                        pre_reg    <= '0;
                    end
                end
                st_run: begin
                    if (i_pause) begin
                        state_reg <= st_pause;
                    end else if (active_time == '0) begin
                        // Covers both a countdown to zero and handing the turn to an empty clock.
                        state_reg <= st_flag;
                        flag_reg  <= active_reg;
                        win_reg   <= ~active_reg;
                    end else if (|(i_move & active_reg)) begin
                        for (int k = 0; k < p_players; k++) begin
                            if (active_reg[k]) time_reg[k] <= sat_inc(time_reg[k]);
                        end
                        active_reg <= rot(active_reg);
                        pre_reg    <= '0;
                    end else if (pre_reg == pre_last) begin
                        pre_reg <= '0;
                        sec_reg <= 1'b1;
                        for (int k = 0; k < p_players; k++) begin
                            if (active_reg[k] && time_reg[k] != '0)
                                time_reg[k] <= time_reg[k] - p_time_w'(1);
                        end
                    end else begin
                        pre_reg <= pre_reg + pre_w'(1);
                    end
                end
                st_pause: begin
                    if (i_pause) state_reg <= st_run;
                end
                default: ;
            endcase
        end
    end

    for (genvar gi = 0; gi < p_players; gi++) begin : g_time
        assign o_time[gi*p_time_w +: p_time_w] = time_reg[gi];
    end

    assign o_active = active_reg;
    assign o_state  = state_reg;
    assign o_flag   = flag_reg;
    assign o_win    = win_reg;
    assign o_sec    = sec_reg;

endmodule

// File: tb/tb_game_clock_multi.sv
// Directed bench for game_clock_multi: 3 players, 8-bit times, 4-cycle second, increment 2.
module tb_game_clock_multi;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        restart = 1'b0;
    logic        pause = 1'b0;
    logic [2:0]  move = '0;
    logic [7:0]  init = 8'd5;
    logic [23:0] time_bus;
    logic [2:0]  active;
    logic [1:0]  state;
    logic [2:0]  flag;
    logic [2:0]  win;
    logic        sec;

    int n_checks = 0;
    int n_fail   = 0;

    game_clock_multi #(
        .p_players(3), .p_time_w(8), .p_divider(4), .p_increment(2)
    ) dut (
        .i_clk_50m(clk), .i_rst(rst), .i_restart(restart), .i_pause(pause),
        .i_move(move), .i_init(init), .o_time(time_bus), .o_active(active),
        .o_state(state), .o_flag(flag), .o_win(win), .o_sec(sec)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic pulse_move(input logic [2:0] v);
        move = v;
        tick(1);
        move = '0;
    endtask

    task automatic do_restart(input logic [7:0] v);
        init = v;
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
    endtask

    initial begin
        // 1. reset and basic countdown
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_time", 32'(time_bus), 32'h050505);
        chk("rst_active", 32'(active), 32'd0);
        chk("rst_flagwin", 32'({flag, win, sec}), 32'd0);

        pulse_move(3'b100);
        chk("idle_move_active", 32'(active), 32'b001);
        chk("idle_move_state", 32'(state), 32'd1);
        tick(3);
        chk("pre_count_time", 32'(time_bus[7:0]), 32'd5);
        chk("pre_count_sec", 32'(sec), 32'd0);
        tick(1);
        chk("dec1_time", 32'(time_bus[7:0]), 32'd4);
        chk("dec1_sec", 32'(sec), 32'd1);
        tick(1);
        chk("sec_one_cycle", 32'(sec), 32'd0);
        tick(3);
        chk("dec2_time", 32'(time_bus[7:0]), 32'd3);

        // 2. increment with prescaler clear
        pulse_move(3'b001);
        chk("inc_time", 32'(time_bus), 32'h050505);
        chk("inc_active", 32'(active), 32'b010);
        tick(3);
        chk("inc_pre_cleared", 32'(time_bus[15:8]), 32'd5);
        tick(1);
        chk("p1_dec", 32'(time_bus[15:8]), 32'd4);

        // 3. pause at prescaler=2
        tick(2);
        pause = 1'b1;
        tick(1);
        pause = 1'b0;
        chk("pause_state", 32'(state), 32'd2);
        tick(5);
        pulse_move(3'b010);
        tick(5);
        pulse_move(3'b001);
        tick(8);
        chk("pause_time", 32'(time_bus), 32'h050405);
        chk("pause_active", 32'(active), 32'b010);
        pause = 1'b1;
        tick(1);
        pause = 1'b0;
        chk("resume_state", 32'(state), 32'd1);
        tick(1);
        chk("resume_hold", 32'(time_bus[15:8]), 32'd4);
        tick(1);
        chk("resume_dec", 32'(time_bus[15:8]), 32'd3);

        // 5b. active move coincides with terminal count
        tick(3);
        pulse_move(3'b010);
        chk("move_vs_term_time", 32'(time_bus), 32'h050505);
        chk("move_vs_term_sec", 32'(sec), 32'd0);
        chk("move_vs_term_active", 32'(active), 32'b100);

        // 5c. restart together with pause
        init = 8'd2;
        restart = 1'b1;
        pause = 1'b1;
        tick(1);
        restart = 1'b0;
        pause = 1'b0;
        chk("restart_state", 32'(state), 32'd0);
        chk("restart_time", 32'(time_bus), 32'h020202);
        chk("restart_active", 32'(active), 32'd0);

        // 4. player 1 flags
        pulse_move(3'b001);
        chk("flag_run_active", 32'(active), 32'b010);
        tick(8);
        chk("zero_visible_time", 32'(time_bus[15:8]), 32'd0);
        chk("zero_visible_state", 32'(state), 32'd1);
        tick(1);
        chk("flag_state", 32'(state), 32'd3);
        chk("flag_flag", 32'(flag), 32'b010);
        chk("flag_win", 32'(win), 32'b101);
        pulse_move(3'b010);
        pause = 1'b1;
        tick(1);
        pause = 1'b0;
        pulse_move(3'b101);
        tick(6);
        chk("flag_frozen_state", 32'(state), 32'd3);
        chk("flag_frozen_out", 32'({flag, win, active}), 32'({3'b010, 3'b101, 3'b010}));
        chk("flag_frozen_time", 32'(time_bus), 32'h020002);

        // 5a. simultaneous IDLE move picks lowest index
        do_restart(8'd9);
        pulse_move(3'b110);
        chk("multi_move_active", 32'(active), 32'b100);
        chk("multi_move_time", 32'(time_bus), 32'h090909);

        // 2b. increment saturation
        do_restart(8'd255);
        pulse_move(3'b100);
        pulse_move(3'b001);
        chk("sat_time", 32'(time_bus), 32'hFFFFFF);
        chk("sat_active", 32'(active), 32'b010);

        // 6a. zero-time entry from IDLE
        do_restart(8'd0);
        pulse_move(3'b001);
        chk("zero_entry_run", 32'(state), 32'd1);
        tick(1);
        chk("zero_entry_flag", 32'(state), 32'd3);
        chk("zero_entry_flagvec", 32'({flag, win, sec}), 32'({3'b010, 3'b101, 1'b0}));

        // 6b. reset mid-run
        do_restart(8'd7);
        pulse_move(3'b001);
        tick(5);
        chk("midrun_dec", 32'(time_bus[15:8]), 32'd6);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("midrun_rst_state", 32'(state), 32'd0);
        chk("midrun_rst_out", 32'({active, flag, win, sec}), 32'd0);
        chk("midrun_rst_time", 32'(time_bus), 32'h070707);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
